// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, error bit positions,
// controller states and the signed-overflow helper used by the add/sub path.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;

    localparam int ERR_OVF  = 0;
    localparam int ERR_DIV0 = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ONE  = 2'b01,
        ST_ITER = 2'b10
    } state_t;

    // Two's complement overflow: both addends share a sign that the sum lost.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative multiply / divide engine. One 2*WIDTH register is shared:
//   MUL: {partial product high half, multiplier} shifted right, shift-add.
//   DIV: {partial remainder, dividend/quotient} shifted left, restoring subtract.
// The outputs show the value the register will hold after the step in
// progress, so the controller can capture the final result on the last step.
module alu_iter_unit
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    acc_r;
    logic [WIDTH-1:0] opb_r;
    logic             mode_div_r;

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   trial_s;
    logic [W2-1:0]    mul_next_s;
    logic [W2-1:0]    div_next_s;

    // Next-step values for both modes: shift-add for MUL, restoring subtract for DIV.
    always_comb begin
        add_s      = {1'b0, acc_r[W2-1:WIDTH]} + {1'b0, opb_r};
        trial_s    = acc_r[W2-1:WIDTH-1] - {1'b0, opb_r};
        mul_next_s = {W2{1'b0}};
        div_next_s = {W2{1'b0}};
        if (acc_r[0]) begin
            mul_next_s = {add_s, acc_r[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[W2-1:1]};
        end
        if (trial_s[WIDTH]) begin
            div_next_s = {acc_r[W2-2:0], 1'b0};
        end else begin
            div_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    assign product   = mul_next_s;
    assign quotient  = div_next_s[WIDTH-1:0];
    assign remainder = div_next_s[W2-1:WIDTH];

    // Operand load on accept, then one iteration per enabled step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {W2{1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            mode_div_r <= 1'b0;
        end else if (load) begin
            mode_div_r <= mode_div;
            if (mode_div) begin
                acc_r <= {{WIDTH{1'b0}}, a};
                opb_r <= b;
            end else begin
                acc_r <= {{WIDTH{1'b0}}, b};
                opb_r <= a;
            end
        end else if (step) begin
            if (mode_div_r) begin
                acc_r <= div_next_s;
            end else begin
                acc_r <= mul_next_s;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake. ADD, SUB, NOP and
// divide-by-zero finish one edge after accept; MUL/DIV/MOD run WIDTH
// iterations in alu_iter_unit. Results and error code are registered and
// held until the next completion.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c,
    output logic [1:0]           error
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               busy_r;
    logic               done_r;
    logic [W2-1:0]      c_r;
    logic [1:0]         err_r;

    logic               accept_s;
    logic               to_iter_s;
    logic               sub_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic [WIDTH-1:0]   sum_s;
    logic [W2-1:0]      one_c_s;
    logic [1:0]         one_err_s;
    logic [W2-1:0]      iter_c_s;
    logic [W2-1:0]      product_s;
    logic [WIDTH-1:0]   quotient_s;
    logic [WIDTH-1:0]   remainder_s;

    // Accept decode and routing: MUL, and DIV/MOD with a non-zero divisor, iterate.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && start;
        to_iter_s = 1'b0;
        if ((opcode == OP_MUL) ||
            (((opcode == OP_DIV) || (opcode == OP_MOD)) && (b != {WIDTH{1'b0}}))) begin
            to_iter_s = 1'b1;
        end else begin
            to_iter_s = 1'b0;
        end
    end

    // Single-step results: add/sub with sign extension, divide-by-zero, NOP.
    always_comb begin
        sub_s     = (op_r == OP_SUB);
        b_eff_s   = sub_s ? ~b_r : b_r;
        sum_s     = a_r + b_eff_s + {{(WIDTH-1){1'b0}}, sub_s};
        one_c_s   = {W2{1'b0}};
        one_err_s = 2'b00;
        case (op_r)
            OP_ADD, OP_SUB: begin
                one_c_s            = {{WIDTH{sum_s[WIDTH-1]}}, sum_s};
                one_err_s[ERR_OVF] = signed_ovf(a_r[WIDTH-1], b_eff_s[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_DIV, OP_MOD: begin
                // Only reaches the single-step path when the divisor is zero.
                one_err_s[ERR_DIV0] = 1'b1;
            end
            default: begin
                one_c_s   = {W2{1'b0}};
                one_err_s = 2'b00;
            end
        endcase
    end

    // Result selection from the iterative engine on its final step.
    always_comb begin
        iter_c_s = {W2{1'b0}};
        case (op_r)
            OP_MUL:  iter_c_s = product_s;
            OP_DIV:  iter_c_s = {{WIDTH{1'b0}}, quotient_s};
            OP_MOD:  iter_c_s = {{WIDTH{1'b0}}, remainder_s};
            default: iter_c_s = {W2{1'b0}};
        endcase
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_s),
        .step      (state_r == ST_ITER),
        .mode_div  (opcode != OP_MUL),
        .a         (a),
        .b         (b),
        .product   (product_s),
        .quotient  (quotient_s),
        .remainder (remainder_s)
    );

    // Controller: accept, iteration count and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 4'b0000;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            c_r     <= {W2{1'b0}};
            err_r   <= 2'b00;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r   <= opcode;
                        a_r    <= a;
                        b_r    <= b;
                        busy_r <= 1'b1;
                        if (to_iter_s) begin
                            state_r <= ST_ITER;
                            cnt_r   <= CNT_W'(WIDTH);
                        end else begin
                            state_r <= ST_ONE;
                        end
                    end
                end
                ST_ONE: begin
                    c_r     <= one_c_s;
                    err_r   <= one_err_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_ITER: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        c_r     <= iter_c_s;
                        err_r   <= 2'b00;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign c     = c_r;
    assign error = err_r;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a transaction-level reference (arithmetic result plus
// latency) predicts busy/done/c/error every cycle for the WIDTH=16 instance;
// directed transactions pin literal results; a WIDTH=8 instance checks scaling.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic [15:0] a, b;
    logic        busy, done;
    logic [31:0] c;
    logic [1:0]  error;

    logic        start8;
    logic [3:0]  opcode8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] c8;
    logic [1:0]  error8;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
        .busy(busy), .done(done), .c(c), .error(error)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .opcode(opcode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .c(c8), .error(error8)
    );

    always #5 clk = ~clk;

    // Reference: {latency[5:0], error[1:0], c[31:0]} for a 16-bit transaction.
    function automatic logic [39:0] ref_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int          sx, sy, r;
        logic [15:0] r16;
        logic [31:0] rc;
        logic [1:0]  re;
        logic [5:0]  lat;
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        r   = 0;
        rc  = 32'h0;
        re  = 2'b00;
        lat = 6'd1;
        case (op)
            4'd1, 4'd2: begin
                r     = (op == 4'd1) ? (sx + sy) : (sx - sy);
                r16   = r[15:0];
                rc    = {{16{r16[15]}}, r16};
                re[0] = (r > 32767) || (r < -32768);
            end
            4'd3: begin
                rc  = {16'h0, x} * {16'h0, y};
                lat = 6'd16;
            end
            4'd4, 4'd5: begin
                if (y == 16'h0) begin
                    re = 2'b10;
                end else begin
                    rc  = (op == 4'd4) ? {16'h0, x / y} : {16'h0, x % y};
                    lat = 6'd16;
                end
            end
            default: ;
        endcase
        return {lat, re, rc};
    endfunction

    logic [39:0] ref_now;
    assign ref_now = ref_op(opcode, a, b);

    int          m_left;
    logic        m_done;
    logic [31:0] m_c, p_c;
    logic [1:0]  m_err, p_err;

    // Transaction model: accept when idle, complete after the reference latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_c    <= 32'h0;
            m_err  <= 2'b00;
            p_c    <= 32'h0;
            p_err  <= 2'b00;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_c    <= p_c;
                    m_err  <= p_err;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                p_c    <= ref_now[31:0];
                p_err  <= ref_now[33:32];
                m_left <= int'(ref_now[39:34]);
            end
        end
    end

    // Every-cycle comparison of the 16-bit instance against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ({busy, done, c, error} !== {(m_left != 0), m_done, m_c, m_err}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t busy=%b done=%b c=%h err=%b required busy=%b done=%b c=%h err=%b",
                         $time, busy, done, c, error, (m_left != 0), m_done, m_c, m_err);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Start one transaction at a negedge; optionally pulse a foreign start while busy.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] ec, input logic [1:0] ee, input int elat, input int poke);
        int lat;
        start = 1'b1; opcode = op; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        lat = 0;
        while (busy && lat < 200) begin
            lat++;
            start = (lat == poke);
            if (start) begin
                opcode = 4'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_lat"},  64'(lat),  64'(elat));
        chk({nm, "_done"}, 64'(done), 64'(1));
        chk({nm, "_c"},    64'(c),    64'(ec));
        chk({nm, "_err"},  64'(error), 64'(ee));
    endtask

    task automatic run8(input string nm, input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] ec, input int elat);
        int lat;
        start8 = 1'b1; opcode8 = op; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (busy8 && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        chk({nm, "_lat"},  64'(lat),   64'(elat));
        chk({nm, "_done"}, 64'(done8), 64'(1));
        chk({nm, "_c"},    64'(c8),    64'(ec));
        chk({nm, "_err"},  64'(error8), 64'(0));
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; opcode = 4'd0; a = 16'h0; b = 16'h0;
        start8 = 1'b0; opcode8 = 4'd0; a8 = 8'h0; b8 = 8'h0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {30'h0, busy, done, c}, 64'h0);
        chk("reset_error", 64'(error), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_small",  4'd1, 16'h0004, 16'h0002, 32'h00000006, 2'b00, 1,  -1);
        run_op("add_ovf",    4'd1, 16'h7000, 16'h2000, 32'hFFFF9000, 2'b01, 1,  -1);
        run_op("add_negovf", 4'd1, 16'h8000, 16'h8000, 32'h00000000, 2'b01, 1,  -1);
        run_op("sub_small",  4'd2, 16'h0007, 16'h0002, 32'h00000005, 2'b00, 1,  -1);
        run_op("sub_ovf",    4'd2, 16'h8000, 16'h0001, 32'h00007FFF, 2'b01, 1,  -1);
        run_op("sub_neg",    4'd2, 16'h0002, 16'h0007, 32'hFFFFFFFB, 2'b00, 1,  -1);
        run_op("mul_small",  4'd3, 16'h0007, 16'h0002, 32'h0000000E, 2'b00, 16, -1);
        run_op("mul_max",    4'd3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 2'b00, 16, -1);
        run_op("div_7_2",    4'd4, 16'd7,    16'd2,    32'd3,        2'b00, 16, -1);
        run_op("mod_7_2",    4'd5, 16'd7,    16'd2,    32'd1,        2'b00, 16, -1);
        run_op("div_zero",   4'd4, 16'd7,    16'd0,    32'd0,        2'b10, 1,  -1);
        run_op("mod_zero",   4'd5, 16'd7,    16'd0,    32'd0,        2'b10, 1,  -1);
        run_op("div_big",    4'd4, 16'hFFFF, 16'h0010, 32'h00000FFF, 2'b00, 16, -1);
        run_op("nop",        4'hF, 16'h0005, 16'h0005, 32'd0,        2'b00, 1,  -1);
        run_op("mul_poked",  4'd3, 16'h1234, 16'h0010, 32'h00012340, 2'b00, 16, 4);

        // Abort a division mid-iteration with an asynchronous reset.
        start = 1'b1; opcode = 4'd4; a = 16'h1000; b = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy_done", {62'h0, busy, done}, 64'h0);
        chk("abort_c",   64'(c),     64'h0);
        chk("abort_err", 64'(error), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'h0);

        // Narrow instance: latency follows WIDTH.
        run8("w8_mul_max", 4'd3, 8'hFF, 8'hFF, 16'hFE01, 8);
        run8("w8_div",     4'd4, 8'd200, 8'd7, 16'd28,   8);
        run8("w8_mod",     4'd5, 8'd200, 8'd7, 16'd4,    8);

        // Random traffic, including starts while busy and starts in the done cycle.
        repeat (4000) begin
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 7))
                6:       opcode = 4'hF;
                7:       opcode = 4'h9;
                default: opcode = 4'($urandom_range(0, 5));
            endcase
            a = pick_val();
            b = pick_val();
            @(negedge clk);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
